// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the data stage.
// Optional memory-ack timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          iIfReq,
    input  logic [AW-1:0] iIfAddr,
    output logic [DW-1:0] oIfRdata,
    output logic          oIfDone,
    input  logic          iDmReq,
    input  logic          iDmWr,
    input  logic [AW-1:0] iDmAddr,
    input  logic [DW-1:0] iDmWdata,
    output logic [DW-1:0] oDmRdata,
    output logic          oDmDone,
    output logic          oMemReq,
    output logic          oMemWr,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemWdata,
    input  logic [DW-1:0] iMemRdata,
    input  logic          iMemAck,
    output logic          oErr,
    output logic          oStall
);

    localparam int unsigned SW = 4;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          eff_if, eff_dm, timeout_hit;

    // Done masks stop a requester that still holds its request from being re-granted.
    assign eff_if      = iIfReq & ~if_done_q;
    assign eff_dm      = iDmReq & ~dm_done_q;
    assign timeout_hit = TO_EN && (wait_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = '0;
        dm_rdata_d  = '0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (eff_if && (eff_dm == 1'b0 || starve_q == SW'(STARVE_MAX))) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = iIfAddr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end else if (eff_dm) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = iDmWr;
                    mem_addr_d  = iDmAddr;
                    mem_wdata_d = iDmWdata;
                    if (!eff_if) begin
                        starve_d = '0;
                    end else if (starve_q != SW'(STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (iMemAck || timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    wait_d    = '0;
                    err_d     = ~iMemAck;
                    if (state_q == IF_BUSY) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = iMemAck ? iMemRdata : '0;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = (iMemAck && !mem_wr_q) ? iMemRdata : '0;
                    end
                end else if (TO_EN) begin
                    wait_d = wait_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign oMemReq   = mem_req_q;
    assign oMemWr    = mem_wr_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemWdata = mem_wdata_q;
    assign oIfDone   = if_done_q;
    assign oDmDone   = dm_done_q;
    assign oIfRdata  = if_rdata_q;
    assign oDmRdata  = dm_rdata_q;
    assign oErr      = err_q;
    // Held low in reset so every output reads 0 while resetn is asserted.
    assign oStall    = resetn & (eff_if | eff_dm | (state_q != IDLE));

endmodule
